// File: rtl/sm2_pkg.sv
// Shared SM2 constants and the one-hot state encoding for the projective-to-affine converter.
package sm2_pkg;

  localparam int unsigned WIDTH = 256;

  localparam logic [WIDTH-1:0] P  = 256'hFFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF00000000FFFFFFFFFFFFFFFF;
  localparam logic [WIDTH-1:0] GX = 256'h32C4AE2C1F1981195F9904466A39C9948FE30BBFF2660BE1715A4589334C74C7;
  localparam logic [WIDTH-1:0] GY = 256'hBC3736A2F4F6779C59BDCEE36B692153D0A9877CC62A474002DF32E52139F0A0;

  typedef enum logic [7:0] {
    S_IDLE = 8'b0000_0001,
    S_DIN  = 8'b0000_0010,
    S_INV  = 8'b0000_0100,
    S_M1   = 8'b0000_1000,
    S_M2   = 8'b0001_0000,
    S_M3   = 8'b0010_0000,
    S_M4   = 8'b0100_0000,
    S_FIN  = 8'b1000_0000
  } p2a_state_e;

endpackage

// File: rtl/mod_mul_serial.sv
// MSB-first interleaved modular multiplier: r = a*b mod P, one multiplier bit per cycle.
module mod_mul_serial #(
  parameter int unsigned     WIDTH = sm2_pkg::WIDTH,
  parameter logic [WIDTH-1:0] P    = sm2_pkg::P
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             start,
  output logic [WIDTH-1:0] r,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH+1:0] P2 = {2'b00, P};

  logic [WIDTH+1:0] acc, sum, red1, red2;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CW-1:0]    cnt;
  logic             busy;

  // acc < P, so 2*acc + a < 3P: two conditional subtractions bring it back below P
  always_comb begin
    sum  = (acc << 1) + (b_q[WIDTH-1] ? {2'b00, a_q} : '0);
    red1 = (sum  >= P2) ? sum  - P2 : sum;
    red2 = (red1 >= P2) ? red1 - P2 : red1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc  <= '0;
      a_q  <= '0;
      b_q  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      r    <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        a_q  <= a;
        b_q  <= b;
        acc  <= '0;
        cnt  <= CW'(WIDTH);
        busy <= 1'b1;
      end else if (busy) begin
        acc <= red2;
        b_q <= b_q << 1;
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
          r    <= red2[WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/proj_to_affine.sv
// Jacobian (X,Y,Z) to affine (x,y) for SM2: x = X*Z^-2, y = Y*Z^-3 mod P.
// Optional P2A_ZONE_BYPASS_EN: z==1 skips the inversion and multiplications.
module proj_to_affine #(
  parameter int unsigned      WIDTH = sm2_pkg::WIDTH,
  parameter logic [WIDTH-1:0] P     = sm2_pkg::P
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] y1,
  input  logic [WIDTH-1:0] z1,
  input  logic             start,
  output logic [WIDTH-1:0] x2,
  output logic [WIDTH-1:0] y2,
  output logic             inf,
  output logic             done
);

  import sm2_pkg::*;

  p2a_state_e       state_q, state_nx;
  logic [WIDTH-1:0] x1r, y1r, z1r;
  logic [WIDTH-1:0] u, v, inv_a, inv_b, zi, t, x2r;
  logic [WIDTH-1:0] mul_a, mul_b, mul_r;
  logic             mul_start, mul_done;
  logic             z_zero, u_one, v_one;
`ifdef P2A_ZONE_BYPASS_EN
  logic             z_one;
  assign z_one = (z1r == WIDTH'(1));
`endif

  assign z_zero = (z1r == '0);
  assign u_one  = (u == WIDTH'(1));
  assign v_one  = (v == WIDTH'(1));
  assign zi     = u_one ? inv_a : inv_b;

  // (x+P)/2 for odd x written as (x>>1) + (P>>1) + 1 so no carry bit is needed
  function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] x);
    return (x >> 1) + (x[0] ? (P >> 1) + WIDTH'(1) : '0);
  endfunction

  function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return (x >= y) ? x - y : x - y + P;
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_nx = S_DIN;
      S_DIN: begin
        if (z_zero) state_nx = S_FIN;
`ifdef P2A_ZONE_BYPASS_EN
        else if (z_one) state_nx = S_FIN;
`endif
        else state_nx = S_INV;
      end
      S_INV:   if (u_one || v_one) state_nx = S_M1;
      S_M1:    if (mul_done) state_nx = S_M2;
      S_M2:    if (mul_done) state_nx = S_M3;
      S_M3:    if (mul_done) state_nx = S_M4;
      S_M4:    if (mul_done) state_nx = S_FIN;
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    unique case (state_q)
      S_M1:    begin mul_a = zi;  mul_b = zi; end
      S_M2:    begin mul_a = x1r; mul_b = t;  end
      S_M3:    begin mul_a = t;   mul_b = zi; end
      S_M4:    begin mul_a = y1r; mul_b = t;  end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x1r <= '0; y1r <= '0; z1r <= '0;
      u <= '0; v <= '0; inv_a <= '0; inv_b <= '0;
      t <= '0; x2r <= '0;
      x2 <= '0; y2 <= '0; inf <= 1'b0; done <= 1'b0;
      mul_start <= 1'b0;
    end else begin
      done      <= 1'b0;
      // start pulse lands in the first cycle of each multiply state
      mul_start <= (state_nx != state_q) && (state_nx inside {S_M1, S_M2, S_M3, S_M4});
      unique case (state_q)
        S_IDLE: begin
          x1r <= x1;
          y1r <= y1;
          z1r <= z1;
          if (start) begin
            x2  <= '0;
            y2  <= '0;
            inf <= 1'b0;
          end
        end
        S_DIN: begin
          u     <= z1r;
          v     <= P;
          inv_a <= WIDTH'(1);
          inv_b <= '0;
          if (z_zero) begin
            inf  <= 1'b1;
            done <= 1'b1;
          end
`ifdef P2A_ZONE_BYPASS_EN
          else if (z_one) begin
            x2   <= x1r;
            y2   <= y1r;
            done <= 1'b1;
          end
`endif
        end
        S_INV: begin
          if (!(u_one || v_one)) begin
            if (!u[0]) begin
              u     <= u >> 1;
              inv_a <= half_mod(inv_a);
            end else if (!v[0]) begin
              v     <= v >> 1;
              inv_b <= half_mod(inv_b);
            end else if (u >= v) begin
              u     <= u - v;
              inv_a <= sub_mod(inv_a, inv_b);
            end else begin
              v     <= v - u;
              inv_b <= sub_mod(inv_b, inv_a);
            end
          end
        end
        S_M1: if (mul_done) t   <= mul_r;
        S_M2: if (mul_done) x2r <= mul_r;
        S_M3: if (mul_done) t   <= mul_r;
        S_M4: begin
          if (mul_done) begin
            x2   <= x2r;
            y2   <= mul_r;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  mod_mul_serial #(.WIDTH(WIDTH), .P(P)) u_mul (
    .clk   (clk),
    .rstn  (rstn),
    .a     (mul_a),
    .b     (mul_b),
    .start (mul_start),
    .r     (mul_r),
    .done  (mul_done)
  );

endmodule

// File: tb/tb_proj_to_affine.sv
// Scoreboard bench for proj_to_affine: expectations queued at issue, checked on each done pulse.
module tb_proj_to_affine;
  import sm2_pkg::*;

  typedef logic [255:0] word_t;
  typedef struct {
    word_t x;
    word_t y;
    logic  inf;
    int    lat;
  } exp_t;

`ifdef P2A_ZONE_BYPASS_EN
  localparam int LAT_Z1 = 2;
`else
  localparam int LAT_Z1 = 2 + 1 + 4 * (256 + 2);
`endif
  localparam int BUDGET = 2600;

  logic  clk = 1'b0;
  logic  rstn;
  word_t x1, y1, z1, x2, y2;
  logic  start, inf, done;

  exp_t  sbq[$];
  exp_t  mon_e;
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;
  int    t_start = 0;

  proj_to_affine #(.WIDTH(256), .P(P)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .x1    (x1),
    .y1    (y1),
    .z1    (z1),
    .start (start),
    .x2    (x2),
    .y2    (y2),
    .inf   (inf),
    .done  (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic word_t mulmod(input word_t a, input word_t b);
    logic [511:0] pr;
    pr = {256'b0, a} * {256'b0, b};
    pr = pr % {256'b0, P};
    return pr[255:0];
  endfunction

  function automatic word_t powmod(input word_t base, input word_t e);
    word_t r;
    r = 256'd1;
    for (int i = 255; i >= 0; i--) begin
      r = mulmod(r, r);
      if (e[i]) r = mulmod(r, base);
    end
    return r;
  endfunction

  task automatic chk(input string nm, input word_t act, input word_t req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (rstn === 1'b1 && done !== 1'b0) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=%b want no pulse", done);
      end else begin
        mon_e = sbq.pop_front();
        chk("x2", x2, mon_e.x);
        chk("y2", y2, mon_e.y);
        chk("inf", {255'b0, inf}, {255'b0, mon_e.inf});
        if (mon_e.lat >= 0) chk("latency", word_t'(cyc - t_start), word_t'(mon_e.lat));
      end
    end
  end

  task automatic expect_job(input word_t x, input word_t y, input logic i, input int lat);
    exp_t e;
    e.x = x; e.y = y; e.inf = i; e.lat = lat;
    sbq.push_back(e);
  endtask

  task automatic issue(input word_t x, input word_t y, input word_t z);
    @(negedge clk);
    x1 = x; y1 = y; z1 = z;
    start = 1'b1;
    t_start = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int k;
    k = 0;
    while (done !== 1'b1 && k < BUDGET) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (done !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout_%s: got no done within %0d cycles want done", nm, BUDGET);
    end
    @(negedge clk);
  endtask

  task automatic model_job(input word_t x, input word_t y, input word_t z, output word_t ex, output word_t ey);
    word_t zi, zi2;
    zi  = powmod(z, P - 256'd2);
    zi2 = mulmod(zi, zi);
    ex  = mulmod(x, zi2);
    ey  = mulmod(y, mulmod(zi2, zi));
  endtask

  word_t gx4, gy8, pm1, rx, ry, rz, ex, ey;
  int    pulses;

  initial begin
    gx4 = mulmod(GX, 256'd4);
    gy8 = mulmod(GY, 256'd8);
    pm1 = P - 256'd1;
    rstn = 1'b0; start = 1'b0; x1 = '0; y1 = '0; z1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_x2", x2, '0);
    chk("rst_y2", y2, '0);
    chk("rst_inf_done", {254'b0, inf, done}, '0);
    rstn = 1'b1;
    @(negedge clk);

    // 1: z=1 returns inputs unchanged
    expect_job(GX, GY, 1'b0, LAT_Z1);
    issue(GX, GY, 256'd1);
    wait_done("z1");

    // 2: z=2, with stray start pulses while busy
    expect_job(GX, GY, 1'b0, -1);
    issue(gx4, gy8, 256'd2);
    repeat (3) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (400) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_done("z2");

    // 3: point at infinity
    expect_job('0, '0, 1'b1, 2);
    issue(GX, 256'h1234, 256'd0);
    wait_done("zinf");

    // 4: z=P-1 negates y
    expect_job(GX, P - GY, 1'b0, -1);
    issue(GX, GY, pm1);
    wait_done("zneg");

    // 5: reset mid-inversion; no result may emerge
    issue(gx4, gy8, 256'd2);
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("midrst_x2", x2, '0);
    chk("midrst_y2", y2, '0);
    chk("midrst_inf_done", {254'b0, inf, done}, '0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (2200) @(negedge clk);
    chk("postrst_x2", x2, '0);
    chk("postrst_y2", y2, '0);
    expect_job(GX, GY, 1'b0, -1);
    issue(gx4, gy8, 256'd2);
    wait_done("after_rst");

    // 6: start held high across two back-to-back jobs
    expect_job(GX, GY, 1'b0, -1);
    expect_job(GX, P - GY, 1'b0, -1);
    @(negedge clk);
    x1 = gx4; y1 = gy8; z1 = 256'd2;
    start = 1'b1;
    repeat (3) @(negedge clk);
    x1 = GX; y1 = GY; z1 = pm1;
    pulses = 0;
    for (int k = 0; k < 2 * BUDGET && pulses < 2; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) pulses++;
    end
    start = 1'b0;
    chk("b2b_pulses", word_t'(pulses), 256'd2);
    repeat (3) @(negedge clk);

    // Random vectors against the exponentiation model
    for (int n = 0; n < 6; n++) begin
      for (int k = 0; k < 8; k++) begin
        rx = {rx[223:0], $urandom()};
        ry = {ry[223:0], $urandom()};
        rz = {rz[223:0], $urandom()};
      end
      rx = mulmod(rx, 256'd1);
      ry = mulmod(ry, 256'd1);
      rz = mulmod(rz, 256'd1);
      if (rz == '0) rz = 256'd3;
      model_job(rx, ry, rz, ex, ey);
      expect_job(ex, ey, 1'b0, -1);
      issue(rx, ry, rz);
      wait_done("rand");
    end

    repeat (5) @(negedge clk);
    if (sbq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL pending_expect: got %0d outstanding want 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
